mux_8to1_rr_scheduler: RTL

//  Round-robin scheduler sharing one 8:1 single-bit mux among 8 requesters.

---
 rtl/mux_8to1_rr_scheduler.sv | 112 +++++++++++
 1 files changed

// File: rtl/mux_8to1_rr_scheduler.sv
// mux_8to1_rr_scheduler: round-robin scheduler sharing one 8:1 single-bit mux among 8 requesters
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   req      in   8  request, bit n = requester n wants input i[n]
//   i        in   8  mux data inputs i0..i7
//   s        out  3  mux select {s2,s1,s0}, registered
//   gnt      out  8  one-hot grant, registered (1<<s while granted)
//   y_valid  out  1  sample on y is valid
//   y        out  1  registered sample of i[s]
//   y_ready  in   1  consumer accepts y
//   HOLD_MAX        max consecutive transfers per grant (1..16)
//   ARB_FIXED_PRIO_EN (macro) fixed priority with req[0] highest; ptr stays 0
module mux_8to1_rr_scheduler #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] i,
  output logic [2:0] s,
  output logic [7:0] gnt,
  output logic       y_valid,
  output logic       y,
  input  logic       y_ready
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [4:0] HMAX = 5'(HOLD_MAX);
  state_t     state, state_n;
  logic [2:0] ptr, ptr_n, s_n, rel_ptr, arb_ptr, win;
  logic [7:0] gnt_n;
  logic [4:0] hold_cnt, hold_n;
  logic       y_n, y_valid_n, xfer, stay, rel;
  // First requester at or after p, wrapping 7->0.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    pick = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) pick = idx;
    end
  endfunction
  always_comb begin
    xfer = y_valid & y_ready;
    stay = req[s] && (hold_cnt + 5'd1 < HMAX);
`ifdef ARB_FIXED_PRIO_EN
    rel_ptr = 3'd0;
`else
    rel_ptr = s + 3'd1;
`endif
    rel = (state == GRANT) && xfer && !stay;
    // A release re-arbitrates in the same cycle from the rotated pointer.
    arb_ptr = rel ? rel_ptr : ptr;
    win = pick(req, arb_ptr);
    state_n = state;
    ptr_n = ptr;
    s_n = s;
    gnt_n = gnt;
    y_n = y;
    y_valid_n = y_valid;
    hold_n = hold_cnt;
    if (state == IDLE) begin
      gnt_n = 8'h00;
      y_valid_n = 1'b0;
      if (|req) begin
        state_n = GRANT;
        s_n = win;
        gnt_n = 8'h01 << win;
        y_n = i[win];
        y_valid_n = 1'b1;
        hold_n = 5'd0;
      end
    end else if (xfer) begin
      if (stay) begin
        hold_n = hold_cnt + 5'd1;
        y_n = i[s];
        y_valid_n = 1'b1;
      end else begin
        ptr_n = rel_ptr;
        hold_n = 5'd0;
        if (|req) begin
          s_n = win;
          gnt_n = 8'h01 << win;
          y_n = i[win];
          y_valid_n = 1'b1;
        end else begin
          state_n = IDLE;
          gnt_n = 8'h00;
          y_valid_n = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 3'd0;
      s <= 3'd0;
      gnt <= 8'h00;
      y <= 1'b0;
      y_valid <= 1'b0;
      hold_cnt <= 5'd0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      s <= s_n;
      gnt <= gnt_n;
      y <= y_n;
      y_valid <= y_valid_n;
      hold_cnt <= hold_n;
    end
  end
endmodule
